exp_neg_unit: RTL and testbench

EXP_NEG_UNIT -- requirements
Module: exp_neg_unit

---
 rtl/exp_neg_unit.sv | 99 +++++++++
 tb/tb_exp_neg_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/exp_neg_unit.sv
// exp_neg_unit: iterative Q16.16 exp(-x) using ln2 range reduction and a Taylor series.
// Define EXP_NEG_TRACE_EN to print a trace line on every state transition.
module exp_neg_unit #(
    parameter int WIDTH   = 32,
    parameter int N_TERMS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y,
    output logic                    done
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] INV_LN2 = PW'(32'h0001_7154);
    localparam logic signed [PW-1:0] LN2 = PW'(32'h0000_B172);
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(32'h0001_0000);
    localparam logic [16:0] RECIP [8] = '{17'h0, 17'h10000, 17'h08000, 17'h05555,
                                          17'h04000, 17'h03333, 17'h02AAB, 17'h02492};

    typedef enum logic [2:0] {IDLE, RED1, RED2, SERIES, SCALE, HOLD} state_t;
    state_t state, state_next;

    logic signed [WIDTH-1:0] x_l, n, r, sum, term;
    logic signed [WIDTH-1:0] n_calc, r_calc, tr_a, term_calc;
    logic signed [PW-1:0] p_n, p_ln, p_tr, p_rc, rc;
    logic [3:0] k;
    logic zero;

    // Next term is -(term * r / k), each product truncated back to Q16.16
    always_comb begin
        p_n = PW'(x_l) * INV_LN2;
        n_calc = WIDTH'(p_n >>> WIDTH);
        p_ln = PW'(n) * LN2;
        r_calc = x_l - WIDTH'(p_ln);
        p_tr = PW'(term) * PW'(r);
        tr_a = WIDTH'(p_tr >>> 16);
        rc = PW'(RECIP[k[2:0]]);
        p_rc = PW'(tr_a) * rc;
        term_calc = -WIDTH'(p_rc >>> 16);
    end

    always_comb begin
        state_next = (state == IDLE)   ? (start ? RED1 : IDLE) :
                     (state == RED1)   ? RED2 :
                     (state == RED2)   ? SERIES :
                     (state == SERIES) ? ((k == 4'(N_TERMS - 1)) ? SCALE : SERIES) :
                     (state == SCALE)  ? HOLD :
                     (start ? HOLD : IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            x_l   <= '0;
            n     <= '0;
            zero  <= 1'b0;
            r     <= '0;
            sum   <= '0;
            term  <= '0;
            k     <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE:   if (start) x_l <= x[WIDTH-1] ? '0 : x;
                RED1: begin
                    n    <= n_calc;
                    zero <= n_calc > 16;
                end
                RED2: begin
                    r    <= r_calc[WIDTH-1] ? '0 : r_calc;
                    sum  <= ONE;
                    term <= ONE;
                    k    <= 4'd1;
                end
                SERIES: begin
                    term <= term_calc;
                    sum  <= sum + term_calc;
                    k    <= k + 4'd1;
                end
                SCALE: begin
                    y    <= zero ? '0 : sum >>> n[4:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef EXP_NEG_TRACE_EN
    always @(posedge clk)
        if (!reset && state_next != state)
            $display("%0t exp_neg_unit %s -> %s x=%h n=%0d r=%h sum=%h y=%h",
                     $time, state.name(), state_next.name(), x_l, n, r, sum, y);
`endif
endmodule

// File: tb/tb_exp_neg_unit.sv
// tb_exp_neg_unit: directed vector table, hold/reset corner sequences and random x checked against real exp.
module tb_exp_neg_unit;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic signed [31:0] x = '0;
    logic signed [31:0] y;
    logic done;
    int checks = 0, errors = 0;

    exp_neg_unit #(.WIDTH(32), .N_TERMS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          tol;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp, input int tol);
        longint d;
        d = act - exp;
        checks++;
        if ((d < 0 ? -d : d) > tol) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) +/-%0d", name, act, act, exp, exp, tol);
        end
    endtask

    // One request; latency counted in edges after the edge that samples start
    task automatic run_req(input logic [31:0] xv, output logic [31:0] yv);
        int lat;
        lat = 0;
        @(negedge clk);
        x = xv;
        start = 1'b1;
        @(posedge clk);
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 40);
        yv = y;
        start = 1'b0;
        check("latency", lat, 10, 0);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0, 0);
        check("y_hold", y, yv, 0);
    endtask

    vec_t vt[11];
    logic [31:0] yv, yd, xr;
    int pulses;
    real ex;

    initial begin
        vt[0]  = '{32'h0000_0000, 32'h0001_0000, 0};
        vt[1]  = '{32'h0001_0000, 32'h0000_5E2D, 4};
        vt[2]  = '{32'h0002_0000, 32'h0000_22A5, 4};
        vt[3]  = '{32'h0014_0000, 32'h0000_0000, 0};
        vt[4]  = '{32'hFFFF_0000, 32'h0001_0000, 0};
        vt[5]  = '{32'h0000_8000, 32'h0000_9B45, 4};
        vt[6]  = '{32'h0003_0000, 32'h0000_0CBF, 4};
        vt[7]  = '{32'h000C_0000, 32'h0000_0000, 0};
        vt[8]  = '{32'h8000_0000, 32'h0001_0000, 0};
        vt[9]  = '{32'h000B_0000, 32'h0000_0001, 4};
        vt[10] = '{32'h7FFF_FFFF, 32'h0000_0000, 0};

        #3 reset = 1'b1;
        #1;
        check("reset_y", y, 0, 0);
        check("reset_done", done, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_req(vt[i].x, yv);
            check($sformatf("vec%0d_y", i), yv, vt[i].y, vt[i].tol);
        end

        // start held high: single done, later x change ignored
        @(negedge clk);
        x = 32'h0001_0000;
        start = 1'b1;
        pulses = 0;
        yd = '0;
        @(posedge clk);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                yd = y;
            end
            if (c == 3) x = 32'h0014_0000;
        end
        check("hold_pulses", pulses, 1, 0);
        check("hold_y", y, 32'h5E2D, 4);
        check("hold_y_stable", y, yd, 0);
        start = 1'b0;
        @(posedge clk);

        // reset in the middle of a computation
        @(negedge clk);
        x = 32'h0002_0000;
        start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_y", y, 0, 0);
        check("rst_mid_done", done, 0, 0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            pulses += int'(done);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            pulses += int'(done);
        end
        check("rst_no_done", pulses, 0, 0);
        check("rst_y_zero", y, 0, 0);
        run_req(32'h0002_0000, yv);
        check("rst_restart_y", yv, 32'h22A5, 4);

        for (int i = 0; i < 200; i++) begin
            xr = 32'($urandom_range(12 * 65536 - 1, 0));
            run_req(xr, yv);
            ex = $exp(-real'(xr) / 65536.0) * 65536.0;
            checks++;
            if ((real'(yv) - ex > 4.0) || (ex - real'(yv) > 4.0)) begin
                errors++;
                $display("FAIL rand%0d x=0x%h: got %0d want %f +/-4", i, xr, yv, ex);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
